mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Memory stage of the 64-bit RV64I pipeline, directly downstream of the execute stage.
//  Latches the ALU result, store data and control bits, then performs the data-memory access.
//  Loads/stores use a request/ready handshake; results are formatted and handed to writeback.
//  Stalls upstream (in_ready=0) while a memory access is outstanding.
// PARAMETERS
//  XLEN    64  datapath width; only 64 is supported
//  RD_W     5  destination register index width
// PORTS
//  clk            in   1     rising-edge clock
//  reset          in   1     synchronous, active-high reset
//  in_valid       in   1     execute-stage op valid this cycle
//  in_ready       out  1     stage can accept an op; combinational, =1 iff state==IDLE
//  alu_result     in   64    effective address (mem op) or result (non-mem op)
//  store_data     in   64    rs2 value for stores
//  funct3         in   3     access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  mem_read       in   1     load
//  mem_write      in   1     store; takes priority if mem_read is also set
//  reg_write      in   1     op writes rd
//  rd             in   5     destination register
//  dmem_req       out  1     memory request, held until dmem_ready
//  dmem_we        out  1     1 = write
//  dmem_addr      out  64    doubleword-aligned address: {addr[63:3],3'b000}
//  dmem_wdata     out  64    store_data << (8*addr[2:0])
//  dmem_wstrb     out  8     byte enables
//  dmem_ready     in   1     access complete; dmem_rdata valid in the same cycle
//  dmem_rdata     in   64    read doubleword
//  wb_valid       out  1     one-cycle pulse: result for writeback
//  wb_reg_write   out  1     write enable to register file
//  wb_rd          out  5     destination register
//  wb_data        out  64    formatted load data or passed-through alu_result
//  misalign_err   out  1     one-cycle pulse; only with MEM_MISALIGN_TRAP_EN, else tied 0
// BEHAVIOUR
//  Reset: state=IDLE; every registered output is 0 after the reset edge (dmem_*, wb_*, misalign_err).
//   Reset during ACCESS abandons the access: dmem_req drops and no wb_valid is produced.
//  FSM IDLE -> ACCESS -> IDLE.
//   IDLE: in_ready=1. On in_valid, capture all inputs.
//    Non-mem op: next cycle wb_valid=1, wb_data=alu_result, wb_reg_write=reg_write (latency 1).
//    Mem op: go to ACCESS.
//   ACCESS: dmem_req=1 with addr/we/wdata/wstrb constant; in_ready=0.
//    On the cycle dmem_ready=1: capture and format rdata, then return to IDLE.
//    wb_valid pulses on the following cycle.
//  Stores: wb_reg_write forced 0.
//   wstrb uses funct3[1:0]: B 8'h01, H 8'h03, W 8'h0F, D 8'hFF, each shifted left by addr[2:0].
//   Bits shifted past lane 7 are dropped.
//  Loads: dmem_we=0, wstrb=8'h00.
//   Field = rdata >> (8*addr[2:0]); sign-extend (B/H/W) or zero-extend (BU/HU/WU); D uses field as-is.
//   funct3=111 is treated as LD.
//  Timing: dmem_ready in the first ACCESS cycle gives 2-cycle load latency; dmem_ready outside ACCESS is ignored.
//  in_valid while in_ready=0 is ignored; upstream holds its op until accepted.
//  wb_valid has no backpressure.
//  Back-to-back: a new op may be accepted in the same cycle wb_valid pulses.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   Mem op with addr[2:0] not a multiple of the access size issues no dmem_req.
//   Next cycle: wb_valid=1, wb_reg_write=0, misalign_err=1.
//  Undefined: no check; misaligned accesses truncate at the doubleword boundary as above; misalign_err=0.
// TESTING
//  ALU op: alu_result=64'h1234, reg_write=1, rd=5 -> next cycle wb_valid=1, wb_data=64'h1234, wb_rd=5.
//  SB addr 64'h1003, store_data=64'hAB, dmem_ready 2 cycles after req
//   -> dmem_addr 64'h1000, wstrb 8'h08, wdata[31:24]=8'hAB, in_ready=0 during ACCESS, wb_reg_write=0.
//  LB/LBU addr 64'h2005, rdata byte5=8'h80
//   -> LB wb_data=64'hFFFF_FFFF_FFFF_FF80; LBU wb_data=64'h80.
//  LW/LWU addr 64'h2004, rdata=64'h8000_0001_0000_0000
//   -> LW 64'hFFFF_FFFF_8000_0001; LWU 64'h8000_0001.
//  Reset asserted in ACCESS -> dmem_req=0 after the edge, no wb_valid, in_ready=1.
//   Next op is accepted normally.
//  With MEM_MISALIGN_TRAP_EN: LH addr 64'h2001 -> no dmem_req; misalign_err and wb_valid pulse once.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the RV64I pipeline.
// Accepts one op from execute when idle. Non-memory ops are passed to
// writeback with 1-cycle latency. Loads and stores perform a request/ready
// handshake with data memory, and the result is formatted for writeback.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// memory ops are trapped without issuing a request. When it is undefined,
// misaligned accesses are truncated at the doubleword boundary.
module mem_access_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      funct3,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic [RD_W-1:0] rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Attributes of the op in flight, held for formatting at completion
    logic [2:0]      op_funct3;
    logic [2:0]      op_off;
    logic            op_reg_write;
    logic [RD_W-1:0] op_rd;

    logic            accept;
    logic            is_mem;
    logic            trap;
    logic [7:0]      strb_base;
    logic [7:0]      store_strb;
    logic [XLEN-1:0] store_shifted;
    logic [XLEN-1:0] load_field;
    logic [XLEN-1:0] load_fmt;

    // Decode the incoming op: memory/non-memory, store lanes, and misalignment trap
    always_comb begin
        accept        = in_valid && (state_q == IDLE);
        is_mem        = mem_read || mem_write;
        case (funct3[1:0])
            2'b00:   strb_base = 8'h01;
            2'b01:   strb_base = 8'h03;
            2'b10:   strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
        // Lanes shifted past byte 7 fall off the 8-bit result
        store_strb    = strb_base << alu_result[2:0];
        store_shifted = store_data << {alu_result[2:0], 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
        case (funct3[1:0])
            2'b00:   trap = 1'b0;
            2'b01:   trap = is_mem && alu_result[0];
            2'b10:   trap = is_mem && (alu_result[1:0] != 2'b00);
            default: trap = is_mem && (alu_result[2:0] != 3'b000);
        endcase
`else
        trap          = 1'b0;
`endif
    end

    // Extract the addressed field from the returned doubleword and extend it
    always_comb begin
        load_field = dmem_rdata >> {op_off, 3'b000};
        case (op_funct3)
            3'b000:  load_fmt = {{(XLEN-8){load_field[7]}},   load_field[7:0]};
            3'b001:  load_fmt = {{(XLEN-16){load_field[15]}}, load_field[15:0]};
            3'b010:  load_fmt = {{(XLEN-32){load_field[31]}}, load_field[31:0]};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}},            load_field[7:0]};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}},           load_field[15:0]};
            3'b110:  load_fmt = {{(XLEN-32){1'b0}},           load_field[31:0]};
            default: load_fmt = load_field;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: enter ACCESS on an accepted, non-trapping memory op
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mem && !trap) state_d = ACCESS;
            ACCESS:  if (dmem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: upstream may hand over an op only while idle
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath: capture op, drive the memory request, and produce the writeback pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            op_funct3    <= '0;
            op_off       <= '0;
            op_reg_write <= 1'b0;
            op_rd        <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            if (accept) begin
                op_funct3    <= funct3;
                op_off       <= alu_result[2:0];
                op_reg_write <= reg_write;
                op_rd        <= rd;
                if (!is_mem) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= reg_write;
                    wb_rd        <= rd;
                    wb_data      <= alu_result;
                end else if (trap) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_rd        <= rd;
                    wb_data      <= alu_result;
                    misalign_err <= 1'b1;
                end else begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write;
                    dmem_addr  <= {alu_result[XLEN-1:3], 3'b000};
                    dmem_wdata <= store_shifted;
                    dmem_wstrb <= mem_write ? store_strb : 8'h00;
                end
            end else if ((state_q == ACCESS) && dmem_ready) begin
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= op_rd;
                wb_reg_write <= dmem_we ? 1'b0 : op_reg_write;
                // Stores report their effective address, rebuilt from the aligned address and offset
                wb_data      <= dmem_we ? {dmem_addr[XLEN-1:3], op_off} : load_fmt;
            end
        end
    end

endmodule
